fft_stage_sequencer: RTL and testbench

- Control block for the radix-2 DIT FFT datapath.
- Walks all log2(N) stages of an N-point in-place transform. Issues one butterfly request per handshake: operand addresses A/B, twiddle index, stage number.
- Enforces a stage barrier: the next stage is not issued until every butterfly result of the current stage has been written back.
- Sits between the input buffer (already loaded, bit-reversed order) and the butterfly stage / working memory.

---
 rtl/fft_stage_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - radix-2 DIT FFT stage/butterfly issue sequencer; optional macro FFT_SEQ_INVERSE_EN
module fft_stage_sequencer #(
    parameter int MAX_NUM_OF_SIGNALS = 8,
    parameter int ADDR_W  = $clog2(MAX_NUM_OF_SIGNALS),
    parameter int STAGE_W = ($clog2($clog2(MAX_NUM_OF_SIGNALS)) > 0) ? $clog2($clog2(MAX_NUM_OF_SIGNALS)) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
`ifdef FFT_SEQ_INVERSE_EN
    input  logic               inverse_i,
`endif
    output logic               busy_o,
    output logic               done_o,
    output logic               bfly_valid_o,
    input  logic               bfly_ready_i,
    output logic [ADDR_W-1:0]  addr_a_o,
    output logic [ADDR_W-1:0]  addr_b_o,
    output logic [ADDR_W-2:0]  twiddle_idx_o,
    output logic [STAGE_W-1:0] stage_o,
    output logic               bfly_last_o,
    input  logic               wb_i
);
    localparam int LOG2N  = $clog2(MAX_NUM_OF_SIGNALS);
    localparam int HALF_N = MAX_NUM_OF_SIGNALS / 2;
    localparam int CNT_W  = $clog2(HALF_N + 1);
    localparam int K_W    = ADDR_W - 1;
    localparam logic [K_W-1:0]     K_LAST = K_W'(HALF_N - 1);
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2N - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [K_W-1:0]     r_k, w_k_nxt;
    logic [STAGE_W-1:0] r_stage, w_stage_nxt;
    logic [CNT_W-1:0]   r_outst, w_outst_nxt;
    logic               w_hs;
    logic               w_inv_nxt;
`ifdef FFT_SEQ_INVERSE_EN
    logic               r_inv;
`endif

    logic [ADDR_W-1:0]  w_k_ext, w_half, w_pos, w_addr_a;
    logic [K_W-1:0]     w_tw_fwd, w_tw_nxt;
    logic               w_valid_nxt, w_busy_nxt, w_done_nxt, w_last_nxt;
    logic [ADDR_W-1:0]  w_addr_a_nxt, w_addr_b_nxt;
    logic [K_W-1:0]     w_tw_out_nxt;
    logic [STAGE_W-1:0] w_stage_out_nxt;

    logic               r_valid, r_busy, r_done, r_last;
    logic [ADDR_W-1:0]  r_addr_a, r_addr_b;
    logic [K_W-1:0]     r_tw;
    logic [STAGE_W-1:0] r_stage_out;

    assign w_hs = r_valid & bfly_ready_i;

`ifdef FFT_SEQ_INVERSE_EN
    assign w_inv_nxt = (r_state == ST_IDLE && start_i) ? inverse_i : r_inv;
`else
    assign w_inv_nxt = 1'b0;
`endif

    // Outstanding write-backs: +1 per handshake, -1 per wb_i, stray wb_i at zero ignored
    always_comb begin
        w_outst_nxt = r_outst;
        if (w_hs && !wb_i) begin
            w_outst_nxt = r_outst + CNT_W'(1);
        end else if (!w_hs && wb_i && r_outst != '0) begin
            w_outst_nxt = r_outst - CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_stage <= '0;
            r_outst <= '0;
`ifdef FFT_SEQ_INVERSE_EN
            r_inv   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_stage <= w_stage_nxt;
            r_outst <= w_outst_nxt;
`ifdef FFT_SEQ_INVERSE_EN
            r_inv   <= w_inv_nxt;
`endif
        end
    end

    // Next state: issue a stage, drain it to the barrier, then advance or finish
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_stage_nxt = r_stage;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_ISSUE;
                    w_k_nxt     = '0;
                    w_stage_nxt = '0;
                end
            end
            ST_ISSUE: begin
                if (w_hs) begin
                    w_k_nxt = r_k + K_W'(1);
                    if (r_k == K_LAST) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_outst_nxt == '0) begin
                    if (r_stage == S_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_stage_nxt = r_stage + STAGE_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming request so outputs can be registered
    always_comb begin
        w_k_ext  = ADDR_W'(w_k_nxt);
        w_half   = ADDR_W'(1) << w_stage_nxt;
        w_pos    = w_k_ext & (w_half - ADDR_W'(1));
        w_addr_a = (((w_k_ext >> w_stage_nxt) << w_stage_nxt) << 1) | w_pos;
        w_tw_fwd = K_W'(w_pos << (S_LAST - w_stage_nxt));
        w_tw_nxt = w_inv_nxt ? (K_W'(0) - w_tw_fwd) : w_tw_fwd;

        w_valid_nxt     = (w_state_nxt == ST_ISSUE);
        w_busy_nxt      = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
        w_done_nxt      = (w_state_nxt == ST_DONE);
        w_last_nxt      = w_valid_nxt && (w_stage_nxt == S_LAST) && (w_k_nxt == K_LAST);
        w_addr_a_nxt    = w_valid_nxt ? w_addr_a : '0;
        w_addr_b_nxt    = w_valid_nxt ? (w_addr_a + w_half) : '0;
        w_tw_out_nxt    = w_valid_nxt ? w_tw_nxt : '0;
        w_stage_out_nxt = w_busy_nxt ? w_stage_nxt : '0;
    end

    // Output registers; values stay put while a request waits for ready
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_last      <= 1'b0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_tw        <= '0;
            r_stage_out <= '0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_last      <= w_last_nxt;
            r_addr_a    <= w_addr_a_nxt;
            r_addr_b    <= w_addr_b_nxt;
            r_tw        <= w_tw_out_nxt;
            r_stage_out <= w_stage_out_nxt;
        end
    end

    assign bfly_valid_o  = r_valid;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign bfly_last_o   = r_last;
    assign addr_a_o      = r_addr_a;
    assign addr_b_o      = r_addr_b;
    assign twiddle_idx_o = r_tw;
    assign stage_o       = r_stage_out;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;
    localparam int N     = 8;
    localparam int LOG2N = $clog2(N);
    localparam int AW    = $clog2(N);
    localparam int SW    = ($clog2(LOG2N) > 0) ? $clog2(LOG2N) : 1;
    localparam int HALF  = N / 2;
    localparam int TOTAL = HALF * LOG2N;

    logic          clk_i = 1'b0;
    logic          rst_ni, start_i, bfly_ready_i, wb_i;
    logic          busy_o, done_o, bfly_valid_o, bfly_last_o;
    logic [AW-1:0] addr_a_o, addr_b_o;
    logic [AW-2:0] twiddle_idx_o;
    logic [SW-1:0] stage_o;
`ifdef FFT_SEQ_INVERSE_EN
    logic          inverse_i;
`endif

    fft_stage_sequencer #(.MAX_NUM_OF_SIGNALS(N)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
`ifdef FFT_SEQ_INVERSE_EN
        .inverse_i     (inverse_i),
`endif
        .busy_o        (busy_o),
        .done_o        (done_o),
        .bfly_valid_o  (bfly_valid_o),
        .bfly_ready_i  (bfly_ready_i),
        .addr_a_o      (addr_a_o),
        .addr_b_o      (addr_b_o),
        .twiddle_idx_o (twiddle_idx_o),
        .stage_o       (stage_o),
        .bfly_last_o   (bfly_last_o),
        .wb_i          (wb_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int a;
        int b;
        int tw;
        int st;
        int last;
    } req_t;

    req_t exp_q[$];
    int hs_total, wb_total, pending, done_cnt;
    int ready_mode, wb_mode, g_inv, g_start, g_busy_start, g_stray;
    int bp_left, bp_done, holdoff_cnt, release_flag, release_stage;

    // Reference request list: groups of span 2*half, twiddle step N/span
    function automatic void build_expected(input int inv_v);
        exp_q.delete();
        for (int s = 0; s < LOG2N; s++) begin
            int half = 1 << s;
            int span = 2 * half;
            for (int g = 0; g < N / span; g++) begin
                for (int j = 0; j < half; j++) begin
                    req_t q;
                    q.a  = g * span + j;
                    q.b  = q.a + half;
                    q.tw = j * (N / span);
                    if (inv_v != 0) q.tw = ((N - q.tw) % N) % HALF;
                    q.st = s;
                    q.last = (s == LOG2N - 1 && g == N / span - 1 && j == half - 1) ? 1 : 0;
                    exp_q.push_back(q);
                end
            end
        end
    endfunction

    task automatic cycle();
        int r;
        int w;
        bit hs;
        @(negedge clk_i);
        if (release_flag == 1) begin
            check("release_valid", int'(bfly_valid_o), 1);
            check("release_stage", int'(stage_o), release_stage);
        end else if (release_flag == 2) begin
            check("done_pulse", int'(done_o), 1);
        end
        release_flag = 0;
        if (done_o) done_cnt++;
        if (bfly_valid_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                check("addr_a", int'(addr_a_o), exp_q[0].a);
                check("addr_b", int'(addr_b_o), exp_q[0].b);
                check("twiddle", int'(twiddle_idx_o), exp_q[0].tw);
                check("stage", int'(stage_o), exp_q[0].st);
                check("last", int'(bfly_last_o), exp_q[0].last);
                check("busy", int'(busy_o), 1);
                check("barrier", (wb_total >= exp_q[0].st * HALF) ? 1 : 0, 1);
            end
        end

        r = 1;
        if (ready_mode == 1) r = $urandom_range(0, 1);
        if (ready_mode == 2) begin
            if (hs_total == HALF + 1 && bp_done == 0) begin
                bp_left = 3;
                bp_done = 1;
            end
            if (bp_left > 0) begin
                r = 0;
                bp_left--;
            end
        end

        w = (pending > 0) ? 1 : 0;
        if (wb_mode == 1 && $urandom_range(0, 2) == 0) w = 0;
        if (wb_mode == 2) begin
            if (hs_total < HALF) begin
                w = 0;
            end else if (holdoff_cnt < 10) begin
                w = 0;
                holdoff_cnt++;
                check("holdoff_valid", int'(bfly_valid_o), 0);
                check("holdoff_stage", int'(stage_o), 0);
            end
        end
        if (g_stray != 0) begin
            w = 1;
            g_stray = 0;
        end

        hs = bfly_valid_o && (r != 0);
        if (w != 0 && pending > 0) begin
            pending--;
            wb_total++;
            if (wb_total == hs_total && hs_total % HALF == 0) begin
                release_flag  = (hs_total == TOTAL) ? 2 : 1;
                release_stage = hs_total / HALF;
            end
        end
        if (hs) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            hs_total++;
            pending++;
        end

        bfly_ready_i = r[0];
        wb_i         = w[0];
        start_i      = (g_start != 0) || (g_busy_start != 0 && hs_total == 2);
        g_start      = 0;
`ifdef FFT_SEQ_INVERSE_EN
        inverse_i    = g_inv[0];
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        start_i = 1'b0;
        bfly_ready_i = 1'b0;
        wb_i = 1'b0;
        @(negedge clk_i);
        check("rst_valid", int'(bfly_valid_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_addr_a", int'(addr_a_o), 0);
        check("rst_addr_b", int'(addr_b_o), 0);
        check("rst_twiddle", int'(twiddle_idx_o), 0);
        check("rst_stage", int'(stage_o), 0);
        check("rst_last", int'(bfly_last_o), 0);
        rst_ni = 1'b1;
    endtask

    task automatic run(input int rmode, input int wmode, input int inv_v, input int busy_start, input int abort_at);
        bit fin;
        build_expected(inv_v);
        hs_total = 0; wb_total = 0; pending = 0; done_cnt = 0;
        bp_left = 0; bp_done = 0; holdoff_cnt = 0; release_flag = 0;
        ready_mode = rmode; wb_mode = wmode; g_inv = inv_v;
        g_busy_start = busy_start; g_start = 1;
        fin = 0;
        for (int c = 0; c < 500 && !fin; c++) begin
            cycle();
            if (abort_at > 0 && hs_total >= abort_at) return;
            if (done_cnt > 0) fin = 1;
        end
        check("run_completed", done_cnt, 1);
        g_busy_start = 0;
        repeat (4) cycle();
        check("done_once", done_cnt, 1);
        check("all_issued", hs_total, TOTAL);
        check("all_written", wb_total, TOTAL);
        check("queue_empty", exp_q.size(), 0);
        check("idle_busy", int'(busy_o), 0);
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; bfly_ready_i = 1'b0; wb_i = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
        inverse_i = 1'b0;
`endif
        exp_q.delete();
        hs_total = 0; wb_total = 0; pending = 0; done_cnt = 0;
        ready_mode = 0; wb_mode = 0; g_inv = 0; g_start = 0; g_busy_start = 0; g_stray = 0;
        bp_left = 0; bp_done = 0; holdoff_cnt = 0; release_flag = 0; release_stage = 0;
        apply_reset();

        g_stray = 1;
        cycle();
        cycle();

        run(0, 0, 0, 0, 0);
        run(2, 0, 0, 0, 0);
        run(0, 2, 0, 0, 0);
        run(0, 0, 0, 1, 0);
        run(0, 0, 0, 0, HALF + 2);
        apply_reset();
        run(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) run(1, 1, 0, i % 2, 0);
`ifdef FFT_SEQ_INVERSE_EN
        run(0, 0, 1, 0, 0);
        run(1, 1, 1, 0, 0);
        run(0, 0, 0, 0, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
